// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Memop encodings match the dmem load/store unit and pass through the arbiter untouched.
package dmem_arb_pkg;

    typedef logic req_idx_t;

    localparam req_idx_t REQ_CPU = 1'b0;
    localparam req_idx_t REQ_EXT = 1'b1;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    function automatic req_idx_t grant_index(input logic gnt1);
        return gnt1 ? REQ_EXT : REQ_CPU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: combinational grant from the requests plus the
// last_grant register, which resets to REQ_EXT so the CPU wins the first tie.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    req_idx_t last_grant_r;

    // On a tie the requester that did not win last time is served
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last_grant_r == REQ_EXT) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Remember who was served last
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_r <= REQ_EXT;
        end else if (gnt0) begin
            last_grant_r <= REQ_CPU;
        end else if (gnt1) begin
            last_grant_r <= REQ_EXT;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the CPU (requester 0) and an external master
// (requester 1). Optional perf counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int OPW = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            r0_req,
    input  logic            r0_we,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW-1:0]   r0_wdata,
    input  logic [OPW-1:0]  r0_op,
    output logic            r0_gnt,
    output logic            r0_rvalid,
    output logic [DW-1:0]   r0_rdata,
    input  logic            r1_req,
    input  logic            r1_we,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW-1:0]   r1_wdata,
    input  logic [OPW-1:0]  r1_op,
    output logic            r1_gnt,
    output logic            r1_rvalid,
    output logic [DW-1:0]   r1_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [OPW-1:0]  mem_op,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [DW-1:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]     perf_conflict,
    output logic [31:0]     perf_wait1
`endif
);

    logic           gnt0_s;
    logic           gnt1_s;
    logic [AW-1:0]  addr_r;
    logic [DW-1:0]  wdata_r;
    logic [OPW-1:0] op_r;
    logic           pend_vld_r;
    req_idx_t       pend_idx_r;

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req0  (r0_req),
        .req1  (r1_req),
        .gnt0  (gnt0_s),
        .gnt1  (gnt1_s)
    );

    assign r0_gnt = gnt0_s;
    assign r1_gnt = gnt1_s;

    // Steer the granted requester onto dmem; idle cycles replay the held fields
    always_comb begin
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        mem_op    = op_r;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (gnt0_s) begin
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_op    = r0_op;
            if (r0_we) begin
                mem_we = 1'b1;
            end else begin
                mem_re = 1'b1;
            end
        end else if (gnt1_s) begin
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_op    = r1_op;
            if (r1_we) begin
                mem_we = 1'b1;
            end else begin
                mem_re = 1'b1;
            end
        end else begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    // Hold the last issued address/data/op so the bus does not toggle when idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r  <= '0;
            wdata_r <= '0;
            op_r    <= '0;
        end else begin
            addr_r  <= mem_addr;
            wdata_r <= mem_wdata;
            op_r    <= mem_op;
        end
    end

    // Read owner tag: memory answers one cycle after mem_re
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_vld_r <= 1'b0;
            pend_idx_r <= REQ_CPU;
        end else if (mem_re) begin
            pend_vld_r <= 1'b1;
            pend_idx_r <= grant_index(gnt1_s);
        end else begin
            pend_vld_r <= 1'b0;
            pend_idx_r <= pend_idx_r;
        end
    end

    assign r0_rvalid = pend_vld_r && (pend_idx_r == REQ_CPU);
    assign r1_rvalid = pend_vld_r && (pend_idx_r == REQ_EXT);
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_r;
    logic [31:0] wait1_cnt_r;

    // Saturating contention and requester-1 stall counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflict_cnt_r <= 32'd0;
            wait1_cnt_r    <= 32'd0;
        end else begin
            if (r0_req && r1_req && !(&conflict_cnt_r)) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
            if (r1_req && !gnt1_s && !(&wait1_cnt_r)) begin
                wait1_cnt_r <= wait1_cnt_r + 32'd1;
            end else begin
                wait1_cnt_r <= wait1_cnt_r;
            end
        end
    end

    assign perf_conflict = conflict_cnt_r;
    assign perf_wait1    = wait1_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scenario tasks plus a read-return scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [2:0]  r0_op, r1_op;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_op;
    logic        mem_we, mem_re;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflict, perf_wait1;
`endif

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_op(r0_op),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_op(r1_op),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_op(mem_op),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_conflict(perf_conflict), .perf_wait1(perf_wait1)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        idx;
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic        exp_last = 1'b1;
    logic [31:0] mem_arr [0:63];
    bit   [63:0] mem_vld = '0;
    logic [31:0] ref_arr [0:63];
    bit   [63:0] ref_vld = '0;

    function automatic logic [31:0] init_pattern(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        else if (a == 32'h30) return 32'h1234_5678;
        else return a ^ 32'hA5A5_0000;
    endfunction

    // Behavioural dmem: read data appears one cycle after mem_re
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem_arr[mem_addr[7:2]] <= mem_wdata;
            mem_vld[mem_addr[7:2]] <= 1'b1;
        end
        if (mem_re) begin
            mem_rdata <= mem_vld[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]] : init_pattern(mem_addr);
        end
    end

    logic        ev0, ev1;
    logic [31:0] ed0, ed1;
    rd_t         e;

    // Scoreboard monitor: every cycle the return path must match what is due
    always @(posedge clock) begin
        #2;
        if (mon_en) begin
            ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (e.idx) begin ev1 = 1'b1; ed1 = e.data; end
                else begin ev0 = 1'b1; ed0 = e.data; end
            end
            n_cmp++;
            if ({r1_rvalid, r0_rvalid} !== {ev1, ev0}) begin
                n_fail++;
                $display("FAIL rvalid cyc=%0d got r1/r0=%b%b want %b%b", cyc, r1_rvalid, r0_rvalid, ev1, ev0);
            end
            n_cmp++;
            if (r0_rdata !== ed0 || r1_rdata !== ed1) begin
                n_fail++;
                $display("FAIL rdata cyc=%0d got r0=%h r1=%h want r0=%h r1=%h", cyc, r0_rdata, r1_rdata, ed0, ed1);
            end
        end
    end

    function automatic logic [1:0] exp_gnt(input logic q0, input logic q1);
        if (q0 && q1) return exp_last ? 2'b01 : 2'b10;
        else if (q0) return 2'b01;
        else if (q1) return 2'b10;
        else return 2'b00;
    endfunction

    task automatic model_issue(input logic [1:0] g);
        logic [31:0] a;
        if (g[0] || g[1]) begin
            a = g[0] ? r0_addr : r1_addr;
            if (g[0] ? r0_we : r1_we) begin
                ref_arr[a[7:2]] = g[0] ? r0_wdata : r1_wdata;
                ref_vld[a[7:2]] = 1'b1;
            end else begin
                sb.push_back('{idx: g[1], data: ref_vld[a[7:2]] ? ref_arr[a[7:2]] : init_pattern(a), due: cyc + 1});
            end
            exp_last = g[1];
        end
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clock);
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0; r0_op = MOP_W;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1; r1_op = MOP_HU;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0; r0_op = 3'b000;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0; r1_op = 3'b000;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_re} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 000000", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_re});
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_op !== 3'b000 || r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus got addr=%h wdata=%h op=%h want zeros", mem_addr, mem_wdata, mem_op);
        end
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({r1_gnt, r0_gnt} !== eg) begin
                n_fail++;
                $display("FAIL contention_gnt i=%0d got %b want %b", i, {r1_gnt, r0_gnt}, eg);
            end
            n_cmp++;
            if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== (eg[0] ? 32'h10 : 32'h30)) begin
                n_fail++;
                $display("FAIL contention_bus i=%0d got re=%b we=%b addr=%h", i, mem_re, mem_we, mem_addr);
            end
            model_issue(eg);
        end
        idle();
        idle();
    endtask

    task automatic test_withdraw();
        logic [1:0] eg;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h50, 32'hBAD0_BAD0);
        eg = exp_gnt(1'b1, 1'b1);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== eg || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL withdraw_gnt got g=%b we=%b addr=%h want g=%b we=0 addr=10", {r1_gnt, r0_gnt}, mem_we, mem_addr, eg);
        end
        model_issue(eg);
        idle();
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== 2'b00 || mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h10 || mem_wdata === 32'hBAD0_BAD0) begin
            n_fail++;
            $display("FAIL withdraw_idle got g=%b we=%b re=%b addr=%h wdata=%h", {r1_gnt, r0_gnt}, mem_we, mem_re, mem_addr, mem_wdata);
        end
        idle();
    endtask

    task automatic test_single_read();
        logic [1:0] eg;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        eg = exp_gnt(1'b1, 1'b0);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== eg || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || mem_op !== MOP_W) begin
            n_fail++;
            $display("FAIL single_read got g=%b re=%b we=%b addr=%h op=%h", {r1_gnt, r0_gnt}, mem_re, mem_we, mem_addr, mem_op);
        end
        model_issue(eg);
        idle();
        idle();
    endtask

    task automatic test_write_then_read();
        logic [1:0] eg;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h0000_55AA);
        eg = exp_gnt(1'b0, 1'b1);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== eg || mem_we !== 1'b1 || mem_re !== 1'b0 ||
            mem_addr !== 32'h20 || mem_wdata !== 32'h0000_55AA || mem_op !== MOP_HU) begin
            n_fail++;
            $display("FAIL write_issue got g=%b we=%b re=%b addr=%h wdata=%h op=%h", {r1_gnt, r0_gnt}, mem_we, mem_re, mem_addr, mem_wdata, mem_op);
        end
        model_issue(eg);
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        eg = exp_gnt(1'b1, 1'b0);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== eg || mem_we !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL read_after_write got g=%b we=%b re=%b addr=%h", {r1_gnt, r0_gnt}, mem_we, mem_re, mem_addr);
        end
        model_issue(eg);
        idle();
        n_cmp++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h20 || mem_op !== MOP_W) begin
            n_fail++;
            $display("FAIL idle_hold got we=%b re=%b addr=%h op=%h want 0 0 20 %h", mem_we, mem_re, mem_addr, mem_op, MOP_W);
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] eg;
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (r0_gnt !== 1'b1 || mem_re !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_issue got gnt=%b re=%b want 1 1", r0_gnt, mem_re);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        r0_req = 1'b0; r0_addr = 32'h0; r0_op = 3'b000;
        #2;
        n_cmp++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_re} !== 6'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_op !== 3'b000 || r0_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midread_reset got ctl=%b addr=%h rdata=%h want zeros",
                     {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_re}, mem_addr, r0_rdata);
        end
        exp_last = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
        eg = exp_gnt(1'b1, 1'b1);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_tie got %b want 01", {r1_gnt, r0_gnt});
        end
        model_issue(eg);
        idle();
        idle();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        logic [1:0] eg;
        @(negedge clock);
        reset = 1'b0;
        exp_last = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        n_cmp++;
        if (perf_conflict !== 32'd0 || perf_wait1 !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset got %0d/%0d want 0/0", perf_conflict, perf_wait1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
            eg = exp_gnt(1'b1, 1'b1);
            model_issue(eg);
        end
        idle();
        idle();
        n_cmp++;
        if (perf_conflict !== 32'd4 || perf_wait1 !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_counts got conflict=%0d wait1=%0d want 4/2", perf_conflict, perf_wait1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_withdraw();
        test_single_read();
        test_write_then_read();
        test_reset_mid_read();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        idle();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory port (dmem) between the CPU load/store path (requester 0) and a second bus master (requester 1, e.g. program loader or debug/DMA engine).
- Round-robin grant and request/grant handshake.
- Registered read-return tagging, so each requester receives only its own read data with fixed latency.
- Sits between rv32 core / peripheral master and dmem in the system top.

Parameters:
- AW, 32, address width of every port
- DW, 32, data width of every port
- OPW, 3, width of memop (byte/half/word, signed/unsigned encoding, passed through unchanged)

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- r0_req  in  1  requester 0 (CPU) access request; held until r0_gnt
- r0_we  in  1  requester 0 write enable (1 = write, 0 = read)
- r0_addr  in  AW  requester 0 byte address
- r0_wdata  in  DW  requester 0 write data
- r0_op  in  OPW  requester 0 memop
- r0_gnt  out  1  access issued this cycle for requester 0
- r0_rvalid  out  1  read data valid for requester 0
- r0_rdata  out  DW  read data for requester 0
- r1_req, r1_we, r1_addr, r1_wdata, r1_op, r1_gnt, r1_rvalid, r1_rdata  same as above for requester 1
- mem_addr  out  AW  shared memory address
- mem_wdata  out  DW  shared write data
- mem_op  out  OPW  shared memop
- mem_we  out  1  write strobe, one cycle per granted write
- mem_re  out  1  read strobe, one cycle per granted read
- mem_rdata  in  DW  memory read data, valid exactly one cycle after mem_re

Behaviour:
- Reset values:
  - r0_gnt = r1_gnt = 0; r0_rvalid = r1_rvalid = 0
  - mem_we = mem_re = 0; mem_addr, mem_wdata, mem_op = 0
  - last_grant = 1, so requester 0 wins the first tie
- Grant timing:
  - Grant is combinational from the req inputs and the last_grant register.
  - At most one grant per cycle; at most one access issued per cycle.
- Arbitration:
  - Only one requester asserts req: it is granted.
  - Both assert req: the requester not equal to last_grant is granted.
  - last_grant updates to the granted index on the clock edge.
- Handshake:
  - A requester keeps req, we, addr, wdata and op stable until it sees gnt high.
  - Access completes at gnt for writes.
  - Dropping req before gnt withdraws the request legally.
- Memory mux:
  - mem_* outputs carry the granted requester's fields.
  - With no grant: mem_we = mem_re = 0; address, data and op are held at their last values (no toggling).
- Read return:
  - Owner tag register rd_pend (valid bit + index) is loaded on a granted read.
  - Next cycle, rN_rvalid = 1 for the tagged owner only.
  - rN_rdata = mem_rdata for the owner; the other requester's rdata is forced to 0.
  - Read latency from gnt to rvalid = 1 cycle.
- Back-to-back:
  - A new grant may issue in the same cycle a previous read returns.
  - Sustained throughput is 1 access/cycle.
- Fairness:
  - Under continuous contention, grants alternate 0,1,0,1.
  - Maximum wait for either requester is 1 cycle.
- Boundaries:
  - Simultaneous write by one requester and read by the other: arbitration is as above; the loser retries the next cycle.
  - A read immediately after a write to the same address returns the new data (memory's responsibility; the arbiter preserves issue order).
  - Reset asserted mid-read: the pending tag is cleared and the return rvalid is suppressed.
  - An X or idle req never produces mem_we.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, two 32-bit saturating counters are added, cleared by reset:
  - conflict_cnt: cycles with both req high
  - wait1_cnt: cycles with r1_req high and r1_gnt low
- They are exposed as outputs perf_conflict[31:0] and perf_wait1[31:0].
- When undefined, the counters and ports are absent; all other behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - requester index type (1 bit)
  - constants REQ_CPU = 0 and REQ_EXT = 1
  - memop encodings shared with dmem
- One natural sub-module, rr_arb2: two-input round-robin grant logic plus the last_grant register.
- The top holds the mem mux, the read-tag pipeline and the optional counters.

Test Plan:
- Reset release, r0_req=1 read addr 0x10 with mem returning 0xDEADBEEF → r0_gnt in the same cycle, mem_re=1, r0_rvalid=1 with rdata 0xDEADBEEF the next cycle, r1_rvalid stays 0.
- Both req held for 6 cycles, both reads → grant order 0,1,0,1,0,1; each rvalid goes to the matching owner one cycle later.
- r1 write 0x55AA to 0x20 while r0 idle, then r0 read 0x20 → mem_we pulse once for one cycle with r1 fields; r0 reads 0x55AA.
- r0 read granted, reset pulled low on the next cycle before return → no rvalid; all outputs at reset values; first grant after release goes to r0 on a tie.
- r1_req raised then dropped before gnt while r0 is granted → no access issued for r1, mem_we/mem_re never show r1 fields.
- With DMEM_ARB_PERF_EN: 4 contention cycles then idle → perf_conflict=4, perf_wait1=2; without the macro, the build has no perf ports.
